// File: rtl/siso_shift_param.sv
// siso_shift_param: universal shift register (hold / shift / load / rotate)
// advanced by a single-cycle clock-enable tick from an internal divider.
// The optional bidirectional mode is enabled with `define SISO_SHIFT_BIDIR_EN.
// It adds a dir input; dir=1 selects right-hand shift and rotate.
module siso_shift_param #(
  parameter int WIDTH = 4,
  parameter int DIV   = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] pdata_in,
`ifdef SISO_SHIFT_BIDIR_EN
  input  logic             dir,
`endif
  output logic             s_out,
  output logic [WIDTH-1:0] pdata_out,
  output logic             tick,
  output logic             ref_clk,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(DIV + 1);
  localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [1:0] MODE_ROTATE = 2'b11;

  logic [CNT_W-1:0] div_cnt_reg;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic             ref_clk_reg;
  logic             frame_done_reg, frame_done_next;
  logic             right;

  // tick is a decode of the registered divider count, used only as an enable
  assign tick = (div_cnt_reg == DIV_LAST);

`ifdef SISO_SHIFT_BIDIR_EN
  logic dir_reg;

  // Direction is captured on tick cycles so s_out tracks the active direction
  always_ff @(posedge clk) begin
    if (rst)       dir_reg <= 1'b0;
    else if (tick) dir_reg <= dir;
  end

  assign right = dir;
  assign s_out = dir_reg ? sr_reg[0] : sr_reg[WIDTH-1];
`else
  assign right = 1'b0;
  assign s_out = sr_reg[WIDTH-1];
`endif

  // Divider: count 0..DIV-1, wrap on the tick cycle
  always_ff @(posedge clk) begin
    if (rst)       div_cnt_reg <= '0;
    else if (tick) div_cnt_reg <= '0;
    else           div_cnt_reg <= div_cnt_reg + CNT_W'(1);
  end

  // LED reference: toggle once per tick
  always_ff @(posedge clk) begin
    if (rst)       ref_clk_reg <= 1'b0;
    else if (tick) ref_clk_reg <= ~ref_clk_reg;
  end

  // Next-state datapath; everything holds unless this is a tick cycle
  always_comb begin
    sr_next         = sr_reg;
    bit_cnt_next    = bit_cnt_reg;
    frame_done_next = 1'b0;
    if (tick) begin
      case (mode)
        MODE_SHIFT:  sr_next = right ? {sin, sr_reg[WIDTH-1:1]}
                                     : {sr_reg[WIDTH-2:0], sin};
        MODE_LOAD:   sr_next = pdata_in;
        MODE_ROTATE: sr_next = right ? {sr_reg[0], sr_reg[WIDTH-1:1]}
                                     : {sr_reg[WIDTH-2:0], sr_reg[WIDTH-1]};
        default:     sr_next = sr_reg;
      endcase
      if (mode == MODE_LOAD) begin
        bit_cnt_next = '0;
      end else if (mode != MODE_HOLD) begin
        if (bit_cnt_reg == BIT_LAST) begin
          bit_cnt_next    = '0;
          frame_done_next = 1'b1;
        end else begin
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
        end
      end
    end
  end

  // Register state; reset overrides any coincident tick
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg         <= '0;
      bit_cnt_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      sr_reg         <= sr_next;
      bit_cnt_reg    <= bit_cnt_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign pdata_out  = sr_reg;
  assign ref_clk    = ref_clk_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_siso_shift_param.sv
// Testbench for siso_shift_param: a WIDTH=4/DIV=4 instance driven tick by tick
// through a scoreboard, plus a DIV=1 instance for the every-cycle tick case.
module tb_siso_shift_param;

  typedef struct packed {
    logic [3:0] sr;
    logic       fd;
    logic       so;
    logic       rc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] pdata_in = 4'h0;
  logic       dir = 1'b0;
  logic       s_out, tick, ref_clk, frame_done;
  logic [3:0] pdata_out;

  logic       sin_1 = 1'b0;
  logic [1:0] mode_1 = 2'b00;
  logic [3:0] pdata_in_1 = 4'h0;
  logic       s_out_1, tick_1, ref_clk_1, frame_done_1;
  logic [3:0] pdata_out_1;

  int checks = 0;
  int failures = 0;

  exp_t sb[$];
  exp_t e;

  // bench reference model state
  logic [3:0] m_sr = 4'h0;
  int         m_cnt = 0;
  logic       m_ref = 1'b0;
  logic       m_dir = 1'b0;

  always #5 clk = ~clk;

  siso_shift_param #(.WIDTH(4), .DIV(4)) dut (
    .clk(clk), .rst(rst), .sin(sin), .mode(mode), .pdata_in(pdata_in),
`ifdef SISO_SHIFT_BIDIR_EN
    .dir(dir),
`endif
    .s_out(s_out), .pdata_out(pdata_out), .tick(tick), .ref_clk(ref_clk),
    .frame_done(frame_done)
  );

  siso_shift_param #(.WIDTH(4), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .sin(sin_1), .mode(mode_1), .pdata_in(pdata_in_1),
`ifdef SISO_SHIFT_BIDIR_EN
    .dir(1'b0),
`endif
    .s_out(s_out_1), .pdata_out(pdata_out_1), .tick(tick_1), .ref_clk(ref_clk_1),
    .frame_done(frame_done_1)
  );

  // Wait (bounded) for a tick cycle while scrambling inputs, then drive the
  // requested operation, push the model's expectation, and step past the edge.
  task automatic apply_tick(input logic [1:0] m, input logic s, input logic [3:0] p);
    int n;
    logic fd;
    n = 0;
    @(negedge clk);
    while (!tick && n < 16) begin
      sin = 1'($urandom);
      mode = 2'($urandom);
      pdata_in = 4'($urandom);
      @(negedge clk);
      n++;
    end
    if (!tick) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", tick, n);
    end
    mode = m;
    sin = s;
    pdata_in = p;
    fd = 1'b0;
    case (m)
      2'b01: m_sr = m_dir ? {s, m_sr[3:1]} : {m_sr[2:0], s};
      2'b10: m_sr = p;
      2'b11: m_sr = m_dir ? {m_sr[0], m_sr[3:1]} : {m_sr[2:0], m_sr[3]};
      default: ;
    endcase
    if (m == 2'b10) m_cnt = 0;
    else if (m != 2'b00) begin
      if (m_cnt == 3) begin m_cnt = 0; fd = 1'b1; end
      else m_cnt++;
    end
    m_ref = ~m_ref;
    sb.push_back('{sr: m_sr, fd: fd, so: (m_dir ? m_sr[0] : m_sr[3]), rc: m_ref});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pdata_out, s_out, tick, ref_clk, frame_done} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {pdata_out, s_out, tick, ref_clk, frame_done});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_early_tick: tick=%b after 2 edges, required 0", tick);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({tick, ref_clk} !== 2'b10) begin
      failures++;
      $display("FAIL reset_first_tick: tick,ref_clk=%b after 3 edges, required 10", {tick, ref_clk});
    end
    @(posedge clk);
    #1;
    m_ref = 1'b1;
    checks++;
    if ({tick, ref_clk, pdata_out} !== 6'b01_0000) begin
      failures++;
      $display("FAIL reset_ref_toggle: tick,ref_clk,pdata=%b, required 010000", {tick, ref_clk, pdata_out});
    end
    $display("test_reset: first tick on 4th edge, ref_clk=%b", ref_clk);
  endtask

  task automatic test_shift();
    logic [3:0] bits;
    bits = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      apply_tick(2'b01, bits[i], 4'h0);
      e = sb.pop_front();
      checks++;
      if ({pdata_out, frame_done, s_out, ref_clk} !== e) begin
        failures++;
        $display("FAIL shift_%0d: got %b, required %b", 3 - i,
                 {pdata_out, frame_done, s_out, ref_clk}, e);
      end
      $display("shift sin=%b pdata_out=%h frame_done=%b", bits[i], pdata_out, frame_done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL shift_pulse_width: frame_done=%b one clk later, required 0", frame_done);
    end
  endtask

  task automatic test_rotate();
    apply_tick(2'b10, 1'b0, 4'hA);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) apply_tick(2'b11, 1'($urandom), 4'($urandom));
      e = sb.pop_front();
      checks++;
      if ({pdata_out, frame_done, s_out, ref_clk} !== e) begin
        failures++;
        $display("FAIL rotate_%0d: got %b, required %b", i,
                 {pdata_out, frame_done, s_out, ref_clk}, e);
      end
      $display("rotate step %0d pdata_out=%h frame_done=%b", i, pdata_out, frame_done);
    end
  endtask

  task automatic test_hold();
    apply_tick(2'b10, 1'b0, 4'h6);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) apply_tick(2'b00, 1'($urandom), 4'($urandom));
      e = sb.pop_front();
      checks++;
      if ({pdata_out, frame_done, s_out, ref_clk} !== e) begin
        failures++;
        $display("FAIL hold_%0d: got %b, required %b", i,
                 {pdata_out, frame_done, s_out, ref_clk}, e);
      end
      $display("hold step %0d pdata_out=%h", i, pdata_out);
    end
  endtask

  task automatic test_reset_on_tick();
    int n;
    for (int i = 0; i < 2; i++) begin
      apply_tick(2'b01, 1'b1, 4'h0);
      e = sb.pop_front();
      checks++;
      if ({pdata_out, frame_done, s_out, ref_clk} !== e) begin
        failures++;
        $display("FAIL prereset_shift_%0d: got %b, required %b", i,
                 {pdata_out, frame_done, s_out, ref_clk}, e);
      end
    end
    n = 0;
    @(negedge clk);
    while (!tick && n < 16) begin @(negedge clk); n++; end
    mode = 2'b01;
    sin = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_sr = 4'h0; m_cnt = 0; m_ref = 1'b0;
    checks++;
    if ({pdata_out, s_out, tick, ref_clk, frame_done} !== 8'h00) begin
      failures++;
      $display("FAIL reset_on_tick: got %b, required 00000000",
               {pdata_out, s_out, tick, ref_clk, frame_done});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tick !== 1'b1) begin
      failures++;
      $display("FAIL reset_div_restart: tick=%b 3 edges after release, required 1", tick);
    end
    for (int i = 0; i < 4; i++) begin
      apply_tick(2'b01, 1'b1, 4'h0);
      e = sb.pop_front();
      checks++;
      if ({pdata_out, frame_done, s_out, ref_clk} !== e) begin
        failures++;
        $display("FAIL postreset_shift_%0d: got %b, required %b", i,
                 {pdata_out, frame_done, s_out, ref_clk}, e);
      end
      $display("post-reset shift %0d pdata_out=%h frame_done=%b", i, pdata_out, frame_done);
    end
  endtask

  task automatic test_div1();
    logic prev;
    prev = ref_clk_1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tick_1 !== 1'b1 || ref_clk_1 !== ~prev) begin
        failures++;
        $display("FAIL div1_cycle_%0d: tick=%b ref_clk=%b, required 1 %b", i, tick_1, ref_clk_1, ~prev);
      end
      prev = ref_clk_1;
    end
    @(negedge clk);
    mode_1 = 2'b10;
    pdata_in_1 = 4'h9;
    @(posedge clk);
    #1;
    mode_1 = 2'b00;
    checks++;
    if (pdata_out_1 !== 4'h9) begin
      failures++;
      $display("FAIL div1_load: pdata_out=%h, required 9", pdata_out_1);
    end
    $display("div1 load pdata_out=%h", pdata_out_1);
  endtask

`ifdef SISO_SHIFT_BIDIR_EN
  task automatic test_bidir();
    dir = 1'b1;
    m_dir = 1'b1;
    apply_tick(2'b10, 1'b0, 4'h8);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) apply_tick(2'b01, 1'b0, 4'h0);
      e = sb.pop_front();
      checks++;
      if ({pdata_out, frame_done, s_out, ref_clk} !== e) begin
        failures++;
        $display("FAIL bidir_%0d: got %b, required %b", i,
                 {pdata_out, frame_done, s_out, ref_clk}, e);
      end
      $display("bidir step %0d pdata_out=%h s_out=%b", i, pdata_out, s_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_shift();
    test_rotate();
    test_hold();
    test_reset_on_tick();
    test_div1();
`ifdef SISO_SHIFT_BIDIR_EN
    test_bidir();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
